tone_sequencer: RTL and testbench
=================================

// Module: tone_sequencer
// PURPOSE
// Parametrised note sequencer and square-wave tone generator for the jukebox audio path.
// Reads (period, duration) note words from an external synchronous song ROM, plays each note
// for its duration, inserts an articulation gap between notes, and ends or loops at a
// terminator word. Adds play/pause/stop control and a done pulse. Drives the PWM audio pin
// and the amp shutdown pin.
// PARAMETERS
// CLK_FREQ    100_000_000  system clock in Hz
// UNIT_DIV    8            duration unit = CLK_FREQ/UNIT_DIV cycles (default 1/8 s)
// PERIOD_W    20           width of note half-period, in clock cycles
// DUR_W       5            width of note duration, in units
// ADDR_W      6            note index width; song length <= 2**ADDR_W
// SEL_W       2            song select width
// GAP_CYCLES  1_000_000    silent cycles after each note; 0 disables the gap
// PORTS
// clock       in   1        system clock
// rst_n       in   1        asynchronous active-low reset
// song_sel    in   SEL_W    song number; latched on play start
// play        in   1        1-cycle strobe: start from IDLE/DONE, or resume from PAUSED
// pause       in   1        1-cycle strobe: freeze playback
// stop        in   1        1-cycle strobe: abort to IDLE
// loop_en     in   1        sampled at terminator: 1 = restart at index 0
// rom_song    out  SEL_W    latched song number to ROM
// rom_addr    out  ADDR_W   note index to ROM
// rom_period  in   PERIOD_W half-period; 0 = rest. Valid 1 cycle after rom_addr changes
// rom_dur     in   DUR_W    duration in units; 0 = end-of-song terminator
// audio_out   out  1        square-wave audio
// aud_sd      out  1        amp enable; 1 in FETCH/PLAY/GAP/PAUSED
// busy        out  1        1 in any state other than IDLE/DONE
// note_idx    out  ADDR_W   index of the current note (= rom_addr)
// song_done   out  1        1-cycle pulse on reaching the terminator or address wrap with loop_en=0
// BEHAVIOUR
// - Reset: state IDLE; audio_out=0, aud_sd=0, busy=0, song_done=0, rom_addr=0, rom_song=0,
//   all counters 0.
// - Strobe priority in the same cycle: stop > pause > play. stop in any state -> IDLE next cycle.
// - IDLE/DONE: on play, latch song_sel into rom_song, set rom_addr=0, go to FETCH.
// - FETCH (1 cycle, covers ROM latency). If rom_dur==0 -> END. Otherwise load period_q=rom_period,
//   units_left=rom_dur, clear prescaler and oscillator, go to PLAY.
// - PLAY: prescaler counts 0..CLK_FREQ/UNIT_DIV-1. On wrap, decrement units_left. At 0 -> GAP,
//   or ADVANCE if GAP_CYCLES==0.
//   Oscillator: counter counts 1..period_q; on reaching period_q it resets and toggles audio_out.
//   If period_q==0 (rest), audio_out is held 0.
// - GAP: audio_out=0 for GAP_CYCLES cycles -> ADVANCE.
// - ADVANCE (1 cycle): if rom_addr == 2**ADDR_W-1 -> END; else rom_addr+1 -> FETCH.
// - END (1 cycle): if loop_en, set rom_addr=0 -> FETCH with no done pulse; else pulse song_done -> DONE.
// - Note length = rom_dur*CLK_FREQ/UNIT_DIV cycles exactly, plus GAP_CYCLES, plus 2 overhead
//   cycles (FETCH, ADVANCE).
// - PAUSED: entered by pause from FETCH/PLAY/GAP. Prescaler, units_left, oscillator and gap
//   counters are frozen; audio_out forced 0.
//   play resumes the saved state with counters intact; audio_out restarts low.
// - pause in IDLE/DONE/PAUSED: ignored. play while busy and not PAUSED: ignored.
//   song_sel changes while busy: ignored.
// - DONE: identical to IDLE except busy=0 and aud_sd=0. rom_addr keeps its last value until the
//   next play.
// - rst_n asserted mid-note: immediate return to reset values. No pending done pulse.
// - Counters size with $clog2. CLK_FREQ/UNIT_DIV is computed at elaboration; no runtime multiply.
// STRUCTURE
// - juke_pkg: state enum {IDLE,FETCH,PLAY,GAP,ADVANCE,END,PAUSED,DONE}, REST_PERIOD=0,
//   END_DUR=0, note half-period constants (A3..A6 at 100 MHz), duration constants (SIXTEENTH..FOUR).
// - One sub-module: square_osc (clock, rst_n, en, period, audio). Contains the period counter
//   and the toggle; outputs 0 when period==0 or en==0.
// - Song ROM stays outside this block. The 7-segment title display stays in the top level.
// TESTING (CLK_FREQ=800, UNIT_DIV=8 -> 100 cycles/unit, GAP_CYCLES=10, ADDR_W=3)
// - ROM {(4,2),(0,1),(x,0)}, play -> audio toggles every 4 cycles for 200 cycles, gap 10,
//   silent 100, song_done 1 pulse. Then busy=0, aud_sd=0.
// - Same ROM with loop_en=1 -> after the terminator, rom_addr returns to 0 and note 0 replays.
//   No song_done pulse.
// - pause at cycle 50 of note 0, hold 37 cycles, play -> audio_out=0 while paused. Remaining
//   note time is exactly 150 cycles.
// - stop mid-GAP -> IDLE next cycle, audio_out=0, busy=0, no song_done. Then play with
//   song_sel=2 -> rom_song=2, rom_addr=0.
// - 8 notes with no terminator -> after index 7 goes straight to END. song_done pulses; rom_addr never wraps to 0.
// - rst_n low during PLAY -> all outputs at reset values asynchronously. play+stop in the same
//   cycle from IDLE -> stays IDLE.

Source files
------------

// File: rtl/juke_pkg.sv
// Shared types and constants for the jukebox tone sequencer.
// Note half-periods assume a 100 MHz clock; durations are in sequencer units.
package juke_pkg;

    typedef enum logic [2:0] {
        IDLE, FETCH, PLAY, GAP, ADVANCE, END, PAUSED, DONE
    } state_t;

    localparam int unsigned REST_PERIOD = 0;
    localparam int unsigned END_DUR     = 0;

    // Half-period = 100e6 / (2 * f)
    localparam int unsigned A3 = 227_273;
    localparam int unsigned A4 = 113_636;
    localparam int unsigned A5 = 56_818;
    localparam int unsigned A6 = 28_409;

    localparam int unsigned SIXTEENTH = 1;
    localparam int unsigned EIGHTH    = 2;
    localparam int unsigned QUARTER   = 4;
    localparam int unsigned HALF      = 8;
    localparam int unsigned FOUR      = 16;

endpackage

// File: rtl/square_osc.sv
// Square-wave oscillator: toggles every `period` enabled cycles.
// Disabling holds the count but drops the phase so output restarts low.
module square_osc
    import juke_pkg::*;
#(
    parameter int unsigned PERIOD_W = 20
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                audio
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_inc;
    logic                phase_q;
    logic                is_rest;

    assign cnt_inc = cnt_q + 1'b1;
    assign is_rest = (period == PERIOD_W'(REST_PERIOD));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (clr) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en) begin
            phase_q <= 1'b0;
        end else if (!is_rest) begin
            if (cnt_inc == period) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign audio = en && !is_rest && phase_q;

endmodule

// File: rtl/tone_sequencer.sv
// Note sequencer: walks (period, duration) words from an external song ROM and
// drives the square-wave audio pin, with gap, loop, pause/resume and stop.
module tone_sequencer
    import juke_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned UNIT_DIV   = 8,
    parameter int unsigned PERIOD_W   = 20,
    parameter int unsigned DUR_W      = 5,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned GAP_CYCLES = 1_000_000
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    song_sel,
    input  logic                play,
    input  logic                pause,
    input  logic                stop,
    input  logic                loop_en,
    output logic [SEL_W-1:0]    rom_song,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PERIOD_W-1:0] rom_period,
    input  logic [DUR_W-1:0]    rom_dur,
    output logic                audio_out,
    output logic                aud_sd,
    output logic                busy,
    output logic [ADDR_W-1:0]   note_idx,
    output logic                song_done
);

    localparam int unsigned UNIT_CYCLES = CLK_FREQ / UNIT_DIV;
    localparam int unsigned PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(UNIT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t              state_q, state_d, saved_q, saved_d;
    logic [SEL_W-1:0]    song_q, song_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DUR_W-1:0]    units_q, units_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                done_q, done_d;
    logic                osc_clr;

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        song_d   = song_q;
        addr_d   = addr_q;
        period_d = period_q;
        units_d  = units_q;
        pre_d    = pre_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        osc_clr  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (play && !stop) begin
                    song_d  = song_sel;
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (rom_dur == DUR_W'(END_DUR)) begin
                    state_d = END;
                end else begin
                    period_d = rom_period;
                    units_d  = rom_dur;
                    pre_d    = '0;
                    osc_clr  = 1'b1;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (pre_q == PRE_LAST) begin
                    pre_d   = '0;
                    units_d = units_q - 1'b1;
                    if (units_q == DUR_W'(1)) begin
                        gap_d = '0;
                        if (GAP_CYCLES == 0) state_d = ADVANCE;
                        else                 state_d = GAP;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = ADVANCE;
                else                   gap_d = gap_q + 1'b1;
            end
            ADVANCE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = END;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = FETCH;
                end
            end
            END: begin
                if (loop_en) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            PAUSED:  state_d = PAUSED;
            default: state_d = IDLE;
        endcase

        // The strobe cycle itself still counts; pause parks the state that would follow it.
        if (stop) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else if (pause && (state_q inside {FETCH, PLAY, GAP})) begin
            saved_d = state_d;
            state_d = PAUSED;
        end else if (play && state_q == PAUSED) begin
            state_d = saved_q;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            saved_q  <= IDLE;
            song_q   <= '0;
            addr_q   <= '0;
            period_q <= '0;
            units_q  <= '0;
            pre_q    <= '0;
            gap_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            song_q   <= song_d;
            addr_q   <= addr_d;
            period_q <= period_d;
            units_q  <= units_d;
            pre_q    <= pre_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
        end
    end

    square_osc #(
        .PERIOD_W (PERIOD_W)
    ) u_osc (
        .clock  (clock),
        .rst_n  (rst_n),
        .clr    (osc_clr),
        .en     (state_q == PLAY),
        .period (period_q),
        .audio  (audio_out)
    );

    assign busy      = !(state_q == IDLE || state_q == DONE);
    assign aud_sd    = state_q inside {FETCH, PLAY, GAP, PAUSED};
    assign rom_song  = song_q;
    assign rom_addr  = addr_q;
    assign note_idx  = addr_q;
    assign song_done = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: 100 cycles/unit, 10-cycle gap, 8-entry songs.
module tb_tone_sequencer;

    localparam int U   = 100;
    localparam int GAP = 10;

    logic        clock = 1'b0;
    logic        rst_n, play, pause, stop, loop_en;
    logic [1:0]  song_sel, rom_song;
    logic [2:0]  rom_addr, note_idx;
    logic [19:0] rom_period;
    logic [4:0]  rom_dur;
    logic        audio_out, aud_sd, busy, song_done;

    logic [19:0] rom_p [4][8];
    logic [4:0]  rom_d [4][8];
    logic [3:0]  exp_q [$];  // {audio, aud_sd, busy, song_done} per cycle

    int errors = 0;
    int checks = 0;

    typedef struct {
        int per;
        int dur;
        int exp_busy;
        int exp_high;
    } vec_t;
    vec_t vecs [6];

    assign rom_period = rom_p[rom_song][rom_addr];
    assign rom_dur    = rom_d[rom_song][rom_addr];

    always #5 clock = ~clock;

    tone_sequencer #(
        .CLK_FREQ   (800),
        .UNIT_DIV   (8),
        .PERIOD_W   (20),
        .DUR_W      (5),
        .ADDR_W     (3),
        .SEL_W      (2),
        .GAP_CYCLES (10)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .song_sel   (song_sel),
        .play       (play),
        .pause      (pause),
        .stop       (stop),
        .loop_en    (loop_en),
        .rom_song   (rom_song),
        .rom_addr   (rom_addr),
        .rom_period (rom_period),
        .rom_dur    (rom_dur),
        .audio_out  (audio_out),
        .aud_sd     (aud_sd),
        .busy       (busy),
        .note_idx   (note_idx),
        .song_done  (song_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic set_note(input int s, input int i, input int p, input int d);
        rom_p[s][i] = 20'(p);
        rom_d[s][i] = 5'(d);
    endtask

    // Leaves the bench sampling the first FETCH cycle.
    task automatic start_play(input int s);
        song_sel = 2'(s);
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    // Expected per-cycle outputs from the note list alone.
    task automatic build_exp(input int s);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            int p = int'(rom_p[s][i]);
            int d = int'(rom_d[s][i]);
            logic a;
            exp_q.push_back(4'b0110);
            if (d == 0) begin
                exp_q.push_back(4'b0010);
                break;
            end
            for (int t = 0; t < d * U; t++) begin
                a = (p == 0) ? 1'b0 : 1'(((t / p) % 2));
                exp_q.push_back({a, 3'b110});
            end
            repeat (GAP) exp_q.push_back(4'b0110);
            exp_q.push_back(4'b0010);
            if (i == 7) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
    endtask

    task automatic run_song(input string name, input int s);
        int bad = 0;
        int first = -1;
        int back = 0;
        logic [3:0] got, got_f, want_f;
        logic [2:0] prev;
        build_exp(s);
        loop_en = 1'b0;
        start_play(s);
        prev = rom_addr;
        foreach (exp_q[i]) begin
            got = {audio_out, aud_sd, busy, song_done};
            if (got !== exp_q[i]) begin
                bad++;
                if (first < 0) begin
                    first = i;
                    got_f = got;
                    want_f = exp_q[i];
                end
            end
            if (rom_addr < prev) back++;
            prev = rom_addr;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_wave: cycle %0d got %b, want %b (%0d bad cycles)",
                     name, first, got_f, want_f, bad);
        end
        check({name, "_addr_no_wrap"}, back, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int busy_n, high_n, dn, done_at;
        int a325, a326, b326, au330, au331;
        int bad;

        rst_n = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
        song_sel = 2'd0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 8; i++) set_note(s, i, 0, 0);

        vecs[0] = '{4, 2, 214, 100};
        vecs[1] = '{3, 1, 114, 49};
        vecs[2] = '{0, 1, 114, 0};
        vecs[3] = '{7, 1, 114, 49};
        vecs[4] = '{100, 3, 314, 100};
        vecs[5] = '{1, 1, 114, 50};

        #2;
        check("rst_audio", int'(audio_out), 0);
        check("rst_aud_sd", int'(aud_sd), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(song_done), 0);
        check("rst_addr", int'(rom_addr), 0);
        check("rst_song", int'(rom_song), 0);
        #20;
        rst_n = 1'b1;
        tick();

        // Single-note songs: busy length and count of high audio cycles.
        foreach (vecs[v]) begin
            set_note(1, 0, vecs[v].per, vecs[v].dur);
            set_note(1, 1, 0, 0);
            start_play(1);
            busy_n = 0;
            high_n = 0;
            for (int k = 0; k < 1000 && busy; k++) begin
                busy_n++;
                high_n += int'(audio_out);
                tick();
            end
            check($sformatf("vec%0d_busy_len", v), busy_n, vecs[v].exp_busy);
            check($sformatf("vec%0d_high", v), high_n, vecs[v].exp_high);
            check($sformatf("vec%0d_done", v), int'(song_done), 1);
            tick();
        end

        set_note(0, 0, 4, 2);
        set_note(0, 1, 0, 1);
        set_note(0, 2, 0, 0);
        run_song("basic", 0);
        check("basic_busy_after", int'(busy), 0);
        check("basic_sd_after", int'(aud_sd), 0);

        // Looping: terminator sends the address back to 0 with no done pulse.
        loop_en = 1'b1;
        start_play(0);
        dn = 0; a325 = -1; a326 = -1; b326 = -1; au330 = -1; au331 = -1;
        for (int k = 0; k < 340; k++) begin
            dn += int'(song_done);
            if (k == 325) a325 = int'(rom_addr);
            if (k == 326) begin
                a326 = int'(rom_addr);
                b326 = int'(busy);
            end
            if (k == 330) au330 = int'(audio_out);
            if (k == 331) au331 = int'(audio_out);
            tick();
        end
        check("loop_addr_at_end", a325, 2);
        check("loop_addr_restart", a326, 0);
        check("loop_busy", b326, 1);
        check("loop_replay_low", au330, 0);
        check("loop_replay_high", au331, 1);
        check("loop_no_done", dn, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        check("loop_stop_idle", int'(busy), 0);

        // Pause after 50 played cycles of a 200-cycle note, for 37 cycles.
        set_note(1, 0, 4, 2);
        set_note(1, 1, 0, 0);
        start_play(1);
        repeat (50) tick();
        pause = 1'b1;
        tick();
        pause = 1'b0;
        bad = 0;
        for (int k = 0; k < 37; k++) begin
            if (audio_out !== 1'b0 || busy !== 1'b1 || aud_sd !== 1'b1) bad++;
            if (k == 36) play = 1'b1;
            tick();
        end
        play = 1'b0;
        check("pause_silent", bad, 0);
        bad = 0;
        done_at = -1;
        for (int r = 0; r < 400 && done_at < 0; r++) begin
            if (r < 150 && int'(audio_out) != ((50 + r) / 4 - 12) % 2) bad++;
            if (song_done) done_at = r;
            else tick();
        end
        check("resume_wave", bad, 0);
        check("resume_done_at", done_at, 163);
        tick();

        // Stop in the gap of note 1, then start a different song.
        stop = 1'b0;
        start_play(0);
        repeat (318) tick();
        check("stop_pre_addr", int'(rom_addr), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_audio", int'(audio_out), 0);
        check("stop_sd", int'(aud_sd), 0);
        dn = 0;
        for (int k = 0; k < 5; k++) begin
            dn += int'(song_done);
            tick();
        end
        check("stop_no_done", dn, 0);
        set_note(2, 0, 4, 1);
        set_note(2, 1, 5, 1);
        set_note(2, 2, 0, 0);
        start_play(2);
        check("restart_song", int'(rom_song), 2);
        check("restart_addr", int'(rom_addr), 0);
        check("restart_busy", int'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Full 8-entry song without terminator.
        for (int i = 0; i < 8; i++) set_note(3, i, i + 1, 1);
        run_song("full8", 3);
        check("full8_last_addr", int'(rom_addr), 7);

        // Asynchronous reset in the middle of a note.
        start_play(1);
        repeat (20) tick();
        check("prereset_busy", int'(busy), 1);
        check("prereset_song", int'(rom_song), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_sd", int'(aud_sd), 0);
        check("async_rst_audio", int'(audio_out), 0);
        check("async_rst_song", int'(rom_song), 0);
        #3;
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            dn += int'(song_done) + int'(busy);
        end
        check("post_rst_quiet", dn, 0);

        // play and stop together from IDLE.
        song_sel = 2'd3;
        play = 1'b1;
        stop = 1'b1;
        tick();
        play = 1'b0;
        stop = 1'b0;
        check("playstop_busy", int'(busy), 0);
        check("playstop_song", int'(rom_song), 0);
        tick();
        check("playstop_busy2", int'(busy), 0);

        // Random songs against the note-list model.
        for (int r = 0; r < 3; r++) begin
            int n = int'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) begin
                if (i < n) set_note(3, i, int'($urandom_range(0, 9)), int'($urandom_range(1, 3)));
                else       set_note(3, i, 0, 0);
            end
            run_song($sformatf("random%0d", r), 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
